// File: rtl/prog_rom_ctrl_pkg.sv
// Shared types and constants for the program ROM sequencing controller.
package prog_rom_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        OPR  = 2'd2,
        MOVC = 2'd3
    } state_e;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_MOVC  = 1'b1;

    localparam int unsigned DEFAULT_ROM_DEPTH = 1041;
    localparam logic [7:0]  DEFAULT_NOP_BYTE  = 8'h00;

endpackage

// File: rtl/rom_req_arb.sv
// Two-requester round-robin arbiter: combinational grant, registered last winner.
module rom_req_arb
    import prog_rom_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic fetch_req_i,
    input  logic movc_req_i,
    input  logic arb_en_i,
    output logic grant_valid_o,
    output logic grant_o
);

    logic last_grant_q;

    always_comb begin
        grant_valid_o = fetch_req_i | movc_req_i;
        if (fetch_req_i && movc_req_i) begin
            grant_o = (last_grant_q == GRANT_FETCH) ? GRANT_MOVC : GRANT_FETCH;
        end else begin
            grant_o = movc_req_i ? GRANT_MOVC : GRANT_FETCH;
        end
    end

    // Winner is only recorded when a grant is actually taken, so idle decision
    // points do not disturb the tie-break order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_FETCH;
        end else if (arb_en_i && grant_valid_o) begin
            last_grant_q <= grant_o;
        end
    end

endmodule

// File: rtl/prog_rom_ctrl.sv
// Program ROM port sequencer: two-byte instruction fetches and one-byte MOVC
// reads, one ROM address per cycle, with registered result bytes.
module prog_rom_ctrl
    import prog_rom_ctrl_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = DEFAULT_ROM_DEPTH,
    parameter logic [7:0]  NOP_BYTE  = DEFAULT_NOP_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_pc,
    output logic        fetch_ack,
    output logic        fetch_valid,
    output logic [7:0]  fetch_opcode,
    output logic [7:0]  fetch_operand,
    input  logic        flush,
    input  logic        movc_req,
    input  logic [15:0] movc_addr,
    output logic        movc_ack,
    output logic        movc_valid,
    output logic [7:0]  movc_data,
    output logic        addr_err,
    output logic        rom_en,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_byte
);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  opcode_stage_q;
    logic        opcode_err_q;
    logic [7:0]  opcode_q, operand_q, movc_data_q;
    logic        fetch_valid_q, movc_valid_q, addr_err_q;

    logic        arb_en, grant_valid, grant_sel;
    logic [15:0] rom_addr_c;
    logic        out_of_range;
    logic [7:0]  cap_byte;

    always_comb begin
        case (state_q)
            OP, MOVC: rom_addr_c = addr_q;
            OPR:      rom_addr_c = addr_q + 16'd1;
            default:  rom_addr_c = '0;
        endcase
    end

    assign out_of_range = 32'(rom_addr_c) >= ROM_DEPTH;
    assign cap_byte     = out_of_range ? NOP_BYTE : rom_byte;

    // A flush in OPR abandons the fetch, so that edge is not a decision point.
    assign arb_en = (state_q == IDLE) || (state_q == MOVC) || ((state_q == OPR) && !flush);

    rom_req_arb u_arb (
        .clk           (clk),
        .rst           (rst),
        .fetch_req_i   (fetch_req & ~flush),
        .movc_req_i    (movc_req),
        .arb_en_i      (arb_en),
        .grant_valid_o (grant_valid),
        .grant_o       (grant_sel)
    );

    // NOTE: every always_comb output gets a default first; any path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            OP:      state_d = flush ? IDLE : OPR;
            OPR:     if (flush) state_d = IDLE;
            default: ;
        endcase
        if (arb_en) begin
            state_d = IDLE;
            if (grant_valid) begin
                state_d = (grant_sel == GRANT_FETCH) ? OP : MOVC;
                addr_d  = (grant_sel == GRANT_FETCH) ? fetch_pc : movc_addr;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            opcode_stage_q <= '0;
            opcode_err_q   <= 1'b0;
            opcode_q       <= '0;
            operand_q      <= '0;
            movc_data_q    <= '0;
            fetch_valid_q  <= 1'b0;
            movc_valid_q   <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            fetch_valid_q <= 1'b0;
            movc_valid_q  <= 1'b0;
            addr_err_q    <= 1'b0;
            case (state_q)
                OP: if (!flush) begin
                    opcode_stage_q <= cap_byte;
                    opcode_err_q   <= out_of_range;
                end
                // Opcode is published together with the operand so a flushed
                // fetch never disturbs the visible instruction bytes.
                OPR: if (!flush) begin
                    opcode_q      <= opcode_stage_q;
                    operand_q     <= cap_byte;
                    fetch_valid_q <= 1'b1;
                    addr_err_q    <= opcode_err_q | out_of_range;
                end
                MOVC: begin
                    movc_data_q  <= cap_byte;
                    movc_valid_q <= 1'b1;
                    addr_err_q   <= out_of_range;
                end
                default: ;
            endcase
        end
    end

    assign rom_en        = (state_q != IDLE);
    assign rom_addr      = rom_addr_c;
    assign fetch_ack     = (state_q == OP);
    assign movc_ack      = (state_q == MOVC);
    assign fetch_valid   = fetch_valid_q;
    assign fetch_opcode  = opcode_q;
    assign fetch_operand = operand_q;
    assign movc_valid    = movc_valid_q;
    assign movc_data     = movc_data_q;
    assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_prog_rom_ctrl.sv
// Self-checking bench for prog_rom_ctrl: vector table, directed corner
// sequences and randomized two-requester traffic against a transaction model.
module tb_prog_rom_ctrl;

    localparam int unsigned DEPTH = 1041;
    localparam logic [7:0]  NOP   = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0, flush = 1'b0, movc_req = 1'b0;
    logic [15:0] fetch_pc = '0, movc_addr = '0;
    logic        fetch_ack, fetch_valid, movc_ack, movc_valid, addr_err, rom_en;
    logic [7:0]  fetch_opcode, fetch_operand, movc_data, rom_byte;
    logic [15:0] rom_addr;

    logic [7:0]  rom_mem [0:DEPTH-1];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic       err;
        int         due;
    } exp_t;

    typedef struct {
        string       name;
        logic        is_movc;
        logic [15:0] addr;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
        logic        exp_err;
    } vec_t;

    exp_t fq[$];
    exp_t mq[$];
    exp_t mon_e;
    logic mon_en = 1'b0;

    prog_rom_ctrl #(.ROM_DEPTH(DEPTH), .NOP_BYTE(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .fetch_ack     (fetch_ack),
        .fetch_valid   (fetch_valid),
        .fetch_opcode  (fetch_opcode),
        .fetch_operand (fetch_operand),
        .flush         (flush),
        .movc_req      (movc_req),
        .movc_addr     (movc_addr),
        .movc_ack      (movc_ack),
        .movc_valid    (movc_valid),
        .movc_data     (movc_data),
        .addr_err      (addr_err),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_byte      (rom_byte)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Out-of-range addresses return a non-NOP pattern so substitution is visible.
    always_comb begin
        rom_byte = 8'hA5;
        if (32'(rom_addr) < DEPTH) rom_byte = rom_mem[rom_addr[10:0]];
    end

    function automatic logic oor(input logic [15:0] a);
        return 32'(a) >= DEPTH;
    endfunction

    function automatic logic [7:0] golden(input logic [15:0] a);
        return oor(a) ? NOP : rom_mem[a[10:0]];
    endfunction

    function automatic logic [15:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 7)      return 16'($urandom_range(0, DEPTH - 1));
        else if (r < 9) return 16'($urandom_range(DEPTH - 6, DEPTH + 60));
        else            return 16'hFFF0 + 16'($urandom_range(0, 15));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_en"}, rom_en, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_acks"}, {fetch_ack, movc_ack}, 0);
        check({tag, "_valids"}, {fetch_valid, movc_valid, addr_err}, 0);
        check({tag, "_data"}, {fetch_opcode, fetch_operand, movc_data}, 0);
    endtask

    // Single isolated transfer from IDLE with fixed expected timing.
    task automatic run_xfer(input logic is_movc, input logic [15:0] addr,
                            output logic [7:0] d0, output logic [7:0] d1, output logic err);
        logic [15:0] nxt = addr + 16'd1;
        if (is_movc) begin movc_addr = addr; movc_req = 1'b1; end
        else begin fetch_pc = addr; fetch_req = 1'b1; end
        tick();
        check("ack_next_cycle", is_movc ? movc_ack : fetch_ack, 1);
        check("ack_rom_addr", rom_addr, addr);
        movc_req  = 1'b0;
        fetch_req = 1'b0;
        if (!is_movc) begin
            tick();
            check("opr_rom_addr", rom_addr, nxt);
            check("no_early_valid", fetch_valid, 0);
        end
        tick();
        check("valid_pulse", is_movc ? movc_valid : fetch_valid, 1);
        d0  = is_movc ? movc_data : fetch_opcode;
        d1  = is_movc ? 8'h00 : fetch_operand;
        err = addr_err;
        tick();
        check("valid_one_cycle", {fetch_valid, movc_valid, addr_err}, 0);
        check("data_hold", is_movc ? movc_data : fetch_opcode, d0);
    endtask

    task automatic agent(input logic is_movc, input int n);
        logic [15:0] a, a1;
        logic        acked;
        exp_t        e;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            a  = rand_addr();
            a1 = a + 16'd1;
            if (is_movc) begin movc_addr = a; movc_req = 1'b1; end
            else begin fetch_pc = a; fetch_req = 1'b1; end
            acked = 1'b0;
            for (int w = 0; w < 6 && !acked; w++) begin
                tick();
                acked = is_movc ? movc_ack : fetch_ack;
            end
            if (is_movc) movc_req = 1'b0;
            else fetch_req = 1'b0;
            check(is_movc ? "rnd_movc_ack_timeout" : "rnd_fetch_ack_timeout", acked, 1);
            if (acked) begin
                check("rnd_ack_rom_addr", rom_addr, a);
                e.d0 = golden(a);
                if (is_movc) begin
                    e.d1 = 8'h00; e.err = oor(a); e.due = cyc + 1;
                    mq.push_back(e);
                end else begin
                    e.d1 = golden(a1); e.err = oor(a) | oor(a1); e.due = cyc + 2;
                    fq.push_back(e);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (fetch_valid) begin
                if (fq.size() == 0) check("rnd_unexpected_fetch_valid", fetch_valid, 0);
                else begin
                    mon_e = fq.pop_front();
                    check("rnd_fetch_opcode", fetch_opcode, mon_e.d0);
                    check("rnd_fetch_operand", fetch_operand, mon_e.d1);
                    check("rnd_fetch_err", addr_err, mon_e.err);
                    check("rnd_fetch_latency", cyc, mon_e.due);
                end
            end else if (movc_valid) begin
                if (mq.size() == 0) check("rnd_unexpected_movc_valid", movc_valid, 0);
                else begin
                    mon_e = mq.pop_front();
                    check("rnd_movc_data", movc_data, mon_e.d0);
                    check("rnd_movc_err", addr_err, mon_e.err);
                    check("rnd_movc_latency", cyc, mon_e.due);
                end
            end else begin
                check("rnd_err_without_valid", addr_err, 0);
            end
        end
    end

    initial begin
        vec_t       vecs [9];
        logic [7:0] d0, d1;
        logic       err;
        logic [7:0] b2b_op  [3];
        logic [7:0] b2b_opr [3];

        for (int i = 0; i < int'(DEPTH); i++) rom_mem[i] = 8'(i * 37 + 11);
        rom_mem[0]     = 8'h02;
        rom_mem[3]     = 8'h74; rom_mem[4]     = 8'h0F;
        rom_mem[17]    = 8'h70; rom_mem[18]    = 8'h08;
        rom_mem[19]    = 8'hE5; rom_mem[20]    = 8'h90;
        rom_mem[21]    = 8'h24; rom_mem[22]    = 8'h01;
        rom_mem[59]    = 8'h74; rom_mem[60]    = 8'h01;
        rom_mem[62]    = 8'h90;
        rom_mem[1039]  = 8'h33; rom_mem[1040]  = 8'h5A;

        vecs[0] = '{"fetch_0003",      1'b0, 16'h0003, 8'h74, 8'h0F, 1'b0};
        vecs[1] = '{"fetch_wrap_ffff", 1'b0, 16'hFFFF, 8'h00, 8'h02, 1'b1};
        vecs[2] = '{"fetch_top_in",    1'b0, 16'h040F, 8'h33, 8'h5A, 1'b0};
        vecs[3] = '{"fetch_straddle",  1'b0, 16'h0410, 8'h5A, 8'h00, 1'b1};
        vecs[4] = '{"fetch_oor",       1'b0, 16'h0411, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{"movc_003e",       1'b1, 16'h003E, 8'h90, 8'h00, 1'b0};
        vecs[6] = '{"movc_last",       1'b1, 16'h0410, 8'h5A, 8'h00, 1'b0};
        vecs[7] = '{"movc_first_oor",  1'b1, 16'h0411, 8'h00, 8'h00, 1'b1};
        vecs[8] = '{"movc_8000",       1'b1, 16'h8000, 8'h00, 8'h00, 1'b1};

        // Reset state, with both requests already pending.
        fetch_pc = 16'h003B; movc_addr = 16'h003E;
        fetch_req = 1'b1; movc_req = 1'b1;
        tick(); tick();
        check_all_zero("reset");

        // Contention: MOVC wins the first tie, fetch follows with no gap.
        #3 rst = 1'b0;
        tick();
        check("cont_movc_first", {movc_ack, fetch_ack}, 2'b10);
        check("cont_movc_addr", rom_addr, 16'h003E);
        tick();
        check("cont_movc_valid", movc_valid, 1);
        check("cont_movc_data", movc_data, 8'h90);
        check("cont_fetch_wins_tie", {fetch_ack, movc_ack}, 2'b10);
        fetch_req = 1'b0;
        tick();
        check("cont_opr_addr", rom_addr, 16'h003C);
        tick();
        check("cont_fetch_valid", fetch_valid, 1);
        check("cont_fetch_bytes", {fetch_opcode, fetch_operand}, 16'h7401);
        check("cont_movc_regrant", movc_ack, 1);
        movc_req = 1'b0;
        tick();
        check("cont_movc2_valid", {movc_valid, movc_data}, {1'b1, 8'h90});
        tick();

        foreach (vecs[i]) begin
            run_xfer(vecs[i].is_movc, vecs[i].addr, d0, d1, err);
            check({vecs[i].name, "_d0"}, d0, vecs[i].exp0);
            if (!vecs[i].is_movc) check({vecs[i].name, "_d1"}, d1, vecs[i].exp1);
            check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
        end

        // Flush in OPR: no fetch_valid, IDLE next cycle.
        fetch_pc = 16'h000B; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        check("flush_opr_state", rom_addr, 16'h000C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_opr_idle", {rom_en, rom_addr, fetch_valid}, 0);
        tick();
        check("flush_opr_no_valid", fetch_valid, 0);

        // Flush in OP.
        fetch_pc = 16'h0020; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_op_idle", {rom_en, fetch_ack}, 0);
        tick();
        check("flush_op_no_valid", fetch_valid, 0);

        // Asynchronous reset mid-MOVC.
        movc_addr = 16'h003E; movc_req = 1'b1;
        tick();
        check("rst_mid_in_movc", movc_ack, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        movc_req = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        check("rst_mid_no_valid_a", movc_valid, 0);
        tick();
        check("rst_mid_no_valid_b", movc_valid, 0);

        // Back-to-back fetches with fetch_req held high.
        b2b_op  = '{8'h70, 8'hE5, 8'h24};
        b2b_opr = '{8'h08, 8'h90, 8'h01};
        fetch_pc = 16'h0011; fetch_req = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("b2b_ack", fetch_ack, 1);
            if (k < 2) fetch_pc = fetch_pc + 16'd2;
            else fetch_req = 1'b0;
            tick();
            check("b2b_gap", fetch_valid, 0);
            tick();
            check("b2b_valid", fetch_valid, 1);
            check("b2b_bytes", {fetch_opcode, fetch_operand}, {b2b_op[k], b2b_opr[k]});
        end
        tick();

        // Randomized concurrent traffic against the transaction model.
        mon_en = 1'b1;
        fork
            agent(1'b0, 60);
            agent(1'b1, 60);
        join
        repeat (4) tick();
        mon_en = 1'b0;
        check("rnd_fetch_drained", fq.size(), 0);
        check("rnd_movc_drained", mq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
